// File: rtl/q31_five_term_accum_if.sv
// Handshake and data bundle between the Q31 term accumulator and its
// controller / five-way operand mux.
interface q31_five_term_accum_if;
  logic        start;
  logic [31:0] term_in;
  logic [2:0]  sel;
  logic        busy;
  logic        done;
  logic [31:0] acc_out;
  logic        overflow;

  // Controller side: requests runs, supplies the mux output, observes results.
  modport master (
    output start,
    output term_in,
    input  sel,
    input  busy,
    input  done,
    input  acc_out,
    input  overflow
  );

  // Accumulator side.
  modport slave (
    input  start,
    input  term_in,
    output sel,
    output busy,
    output done,
    output acc_out,
    output overflow
  );
endinterface

// File: rtl/q31_five_term_accum.sv
// Sequencer plus saturating (L_add) accumulator over NTERMS Q31 mux terms.
// NTERMS is legal in 1..5; sel walks 0..NTERMS-1, one term per clock.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; sel=0, busy=0
// ACC   | one L_add per clock, sel=term index; result latched on last
// DONE  | one-cycle done strobe; start ignored; returns to IDLE
module q31_five_term_accum #(
  parameter int unsigned NTERMS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  q31_five_term_accum_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NTERMS - 1);

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [31:0] acc, acc_nxt;
  logic        run_ovf, run_ovf_nxt;
  logic [31:0] acc_out_q, acc_out_nxt;
  logic        ovf_q, ovf_nxt;

  logic [31:0] sum_raw;
  logic [31:0] sum_sat;
  logic        sat;

  // L_add: wrap-around sum, clamped when two like-signed operands flip sign.
  always_comb begin
    sum_raw = acc + bus.term_in;
    sat     = (acc[31] == bus.term_in[31]) && (sum_raw[31] != acc[31]);
    sum_sat = sum_raw;
    if (sat) begin
      sum_sat = acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  // State, running sum and published result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      acc       <= 32'd0;
      run_ovf   <= 1'b0;
      acc_out_q <= 32'd0;
      ovf_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      acc       <= acc_nxt;
      run_ovf   <= run_ovf_nxt;
      acc_out_q <= acc_out_nxt;
      ovf_q     <= ovf_nxt;
    end
  end

  // Next-state logic; the final sum is taken straight from the adder so the
  // result lands on the same edge as the last accumulation.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    acc_nxt     = acc;
    run_ovf_nxt = run_ovf;
    acc_out_nxt = acc_out_q;
    ovf_nxt     = ovf_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt     = 32'd0;
          run_ovf_nxt = 1'b0;
          idx_nxt     = 3'd0;
          state_nxt   = ACC;
        end
      end
      ACC: begin
        acc_nxt     = sum_sat;
        run_ovf_nxt = run_ovf | sat;
        if (idx == LAST_IDX) begin
          acc_out_nxt = sum_sat;
          ovf_nxt     = run_ovf | sat;
          idx_nxt     = 3'd0;
          state_nxt   = DONE;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 3'd0;
      end
    endcase
  end

  assign bus.sel      = (state == ACC) ? idx : 3'd0;
  assign bus.busy     = (state == ACC);
  assign bus.done     = (state == DONE);
  assign bus.acc_out  = acc_out_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_q31_five_term_accum.sv
// Directed bench for q31_five_term_accum: default five-term build plus a
// three-term build sharing clock and reset.
module tb_q31_five_term_accum;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] t5 [5];
  logic [31:0] t3 [5];

  q31_five_term_accum_if bus5 ();
  q31_five_term_accum_if bus3 ();

  q31_five_term_accum dut5 (
    .clock (clock),
    .reset (reset),
    .bus   (bus5)
  );

  q31_five_term_accum #(.NTERMS(3)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3)
  );

  always #5 clock = ~clock;

  // Bench-side five-way mux models.
  assign bus5.term_in = (bus5.sel < 3'd5) ? t5[bus5.sel] : 32'hDEAD_BEEF;
  assign bus3.term_in = (bus3.sel < 3'd5) ? t3[bus3.sel] : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle5(input string tag, input logic [31:0] exp_acc, input logic exp_ovf);
    chk({tag, " sel"},      32'(bus5.sel),  32'd0);
    chk({tag, " busy"},     32'(bus5.busy), 32'd0);
    chk({tag, " done"},     32'(bus5.done), 32'd0);
    chk({tag, " acc_out"},  bus5.acc_out,   exp_acc);
    chk({tag, " overflow"}, 32'(bus5.overflow), 32'(exp_ovf));
  endtask

  // One five-term run; glitch_at >= 0 pulses start while sel == glitch_at.
  task automatic run5(input string tag,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [31:0] d, input logic [31:0] e,
                      input logic [31:0] exp_acc, input logic exp_ovf,
                      input logic [31:0] prev_acc, input logic prev_ovf,
                      input int glitch_at);
    t5[0] = a; t5[1] = b; t5[2] = c; t5[3] = d; t5[4] = e;
    @(negedge clock);
    bus5.start = 1'b1;
    @(negedge clock);
    bus5.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s sel%0d", tag, i), 32'(bus5.sel), 32'(i));
      chk($sformatf("%s busy%0d", tag, i), 32'(bus5.busy), 32'd1);
      chk($sformatf("%s nodone%0d", tag, i), 32'(bus5.done), 32'd0);
      chk($sformatf("%s hold%0d", tag, i), bus5.acc_out, prev_acc);
      chk($sformatf("%s holdovf%0d", tag, i), 32'(bus5.overflow), 32'(prev_ovf));
      bus5.start = (i == glitch_at);
      @(negedge clock);
    end
    bus5.start = 1'b0;
    chk({tag, " done"},     32'(bus5.done), 32'd1);
    chk({tag, " busy@done"}, 32'(bus5.busy), 32'd0);
    chk({tag, " sel@done"},  32'(bus5.sel), 32'd0);
    chk({tag, " acc_out"},  bus5.acc_out, exp_acc);
    chk({tag, " overflow"}, 32'(bus5.overflow), 32'(exp_ovf));
    @(negedge clock);
    chk_idle5({tag, " after1"}, exp_acc, exp_ovf);
    @(negedge clock);
    chk_idle5({tag, " after2"}, exp_acc, exp_ovf);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      t5[i] = 32'd0;
      t3[i] = 32'd0;
    end
    bus5.start = 1'b0;
    bus3.start = 1'b0;
    reset = 1'b0;

    // Reset held for three cycles, then ten idle cycles.
    repeat (3) begin
      @(negedge clock);
      chk_idle5("reset", 32'd0, 1'b0);
    end
    reset = 1'b1;
    repeat (10) begin
      @(negedge clock);
      chk_idle5("idle", 32'd0, 1'b0);
    end

    run5("nominal", 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 32'hFFFF_FFF0,
         32'h0000_0005, 32'h0000_0055, 1'b0, 32'd0, 1'b0, -1);
    run5("possat", 32'h4000_0000, 32'h4000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
         32'h0000_0000, 32'h7FFF_FFFE, 1'b1, 32'h0000_0055, 1'b0, -1);
    run5("negsat", 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000,
         32'h0000_0000, 32'h8000_0000, 1'b1, 32'h7FFF_FFFE, 1'b1, -1);
    run5("clean", 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
         32'h0000_0001, 32'h0000_0005, 1'b0, 32'h8000_0000, 1'b1, -1);
    run5("glitch", 32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0400,
         32'h0000_0500, 32'h0000_0F00, 1'b0, 32'h0000_0005, 1'b0, 2);

    // Mid-run reset: clear the published result first so its reset value shows.
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    t5[0] = 32'h0000_1000; t5[1] = 32'h0000_2000; t5[2] = 32'h0000_3000;
    t5[3] = 32'h0000_4000; t5[4] = 32'h0000_5000;
    @(negedge clock);
    bus5.start = 1'b1;
    @(negedge clock);
    bus5.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst sel%0d", i), 32'(bus5.sel), 32'(i));
      @(negedge clock);
    end
    chk("midrst sel3", 32'(bus5.sel), 32'd3);
    reset = 1'b0;
    #1;
    chk_idle5("midrst async", 32'd0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    repeat (8) begin
      @(negedge clock);
      chk_idle5("midrst after", 32'd0, 1'b0);
    end

    // Three-term build: terms past index 2 are large so any extra step shows.
    t3[0] = 32'd7; t3[1] = 32'd8; t3[2] = 32'd9;
    t3[3] = 32'h0010_0000; t3[4] = 32'h0020_0000;
    @(negedge clock);
    bus3.start = 1'b1;
    @(negedge clock);
    bus3.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("n3 sel%0d", i), 32'(bus3.sel), 32'(i));
      chk($sformatf("n3 busy%0d", i), 32'(bus3.busy), 32'd1);
      chk($sformatf("n3 nodone%0d", i), 32'(bus3.done), 32'd0);
      @(negedge clock);
    end
    chk("n3 done",     32'(bus3.done), 32'd1);
    chk("n3 busy@done", 32'(bus3.busy), 32'd0);
    chk("n3 sel@done",  32'(bus3.sel), 32'd0);
    chk("n3 acc_out",  bus3.acc_out, 32'h0000_0018);
    chk("n3 overflow", 32'(bus3.overflow), 32'd0);
    @(negedge clock);
    chk("n3 done off", 32'(bus3.done), 32'd0);
    chk("n3 sel idle", 32'(bus3.sel), 32'd0);
    chk("n3 acc hold", bus3.acc_out, 32'h0000_0018);
    chk("n3 dut5 quiet", 32'(bus5.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/q31_five_term_accum.md
Name: q31_five_term_accum

Overview:
Sequencer and saturating accumulator that consumes the output of the five-way Q31 operand mux in the pre-processor datapath.
- On start, it steps the mux select through terms 0..NTERMS-1 (one per clock) and sums the selected Q31 terms with ITU L_add saturation semantics.
- It then presents the 32-bit result with a one-cycle done strobe.
- Typical use: summing the five high-pass filter product terms (b0·x0, b1·x1, b2·x2, a1·y1, a2·y2) for one pre-processed sample.

Parameters:
NTERMS, 5, number of mux inputs accumulated per run; legal range 1..5; selects 0..NTERMS-1.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
start  input  1  request a new accumulation run; sampled only in IDLE.
term_in  input  32  Q31 term from the mux output; combinational function of sel, valid in the same cycle.
sel  output  3  mux select driven to the five-way Q31 mux.
busy  output  1  high from the cycle after start is accepted until done is asserted.
done  output  1  one-cycle strobe: acc_out holds the new result.
acc_out  output  32  registered Q31 sum; holds its value until the next done.
overflow  output  1  sticky for the run: any L_add in the run saturated; updated together with acc_out.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, sel=0, busy=0, done=0, acc_out=0, overflow=0, internal accumulator=0, term index=0.
- States: IDLE, ACC, DONE.
- IDLE:
  - sel=0, busy=0.
  - start=1 at an edge: clear accumulator and overflow-run flag, index=0, go to ACC.
  - start=0: stay in IDLE.
- ACC:
  - busy=1, sel=index.
  - Each edge: acc <= L_add(acc, term_in); index increments.
  - Edge where index==NTERMS-1: last accumulation; load acc_out with the final sum, overflow with the run flag, go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, sel=0; next edge goes to IDLE.
  - start is ignored in DONE; back-to-back runs need start to be high in IDLE.
- Latency: start accepted at edge k; accumulations at edges k+1..k+NTERMS; done high during the cycle after edge k+NTERMS. For NTERMS=5, done is visible 5 cycles after acceptance. Minimum start-to-start spacing is NTERMS+2 cycles.
- L_add rule: 32-bit two's-complement add.
  - Operands with equal signs and a sum sign that differs from them: result saturates to 0x7FFFFFFF (positive operands) or 0x80000000 (negative operands), and the run flag is set.
  - Saturation applies per step, not only at the end, which matches ITU reference ordering.
- start while busy: ignored, with no restart and no effect on the current run.
- reset asserted mid-run: run abandoned and all outputs return to reset values; no done is produced.
- sel never exceeds NTERMS-1. For NTERMS<5, input 4 of the mux is never selected.
- acc_out and overflow change only at the DONE-entry edge or on reset.

Test Plan:
- Reset then idle: hold reset low 3 cycles, release, start=0 for 10 cycles -> sel=0, busy=0, done=0, acc_out=0, overflow=0 throughout.
- Nominal sum: start 1 cycle; bench mux terms 0x00000010, 0x00000020, 0x00000030, 0xFFFFFFF0, 0x00000005 -> sel sequence 0,1,2,3,4 on consecutive cycles; done 5 cycles after acceptance; acc_out=0x00000055; overflow=0.
- Positive saturation: terms 0x40000000, 0x40000000, 0x00000001, 0xFFFFFFFF, 0 -> step 2 saturates to 0x7FFFFFFF, then +1 stays 0x7FFFFFFF, then −1 gives 0x7FFFFFFE; acc_out=0x7FFFFFFE; overflow=1.
- Negative saturation: terms 0x80000000, 0xFFFFFFFF, 0, 0, 0 -> acc_out=0x80000000; overflow=1. A following clean run with all terms 0x00000001 -> acc_out=0x00000005, overflow=0.
- Start during busy and mid-run reset:
  - start pulsed again at sel=2 -> ignored; single done; result unchanged.
  - Separate run with reset low at sel=3 -> sel=0, busy=0, no done; acc_out keeps its reset value 0.
- NTERMS=3 build: terms 7, 8, 9 -> sel steps 0,1,2 only; done 3 cycles after acceptance; acc_out=0x00000018.
